// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced LSB first over WIDTH bit slots.
// Latency: start accepted at E0, sum/cout written at E(WIDTH), done high for the following cycle.
// Backpressure: start is taken only while ready=1; there is no queuing, and start is ignored in RUN/DONE.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             slot_s;
    logic             slot_c;
    logic [WIDTH-1:0] psum_nxt;
    logic             last_slot;
    logic             accept;

    // The single shared full-adder cell, fed from the operand shift register LSBs.
    always_comb begin
        slot_s    = sa[0] ^ sb[0] ^ carry;
        slot_c    = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        psum_nxt  = {slot_s, psum[WIDTH-1:1]};
        last_slot = (cnt == LAST);
        accept    = (state == S_IDLE) && start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (last_slot) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            sa    <= a;
            sb    <= b;
            psum  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            sa    <= {1'b0, sa[WIDTH-1:1]};
            sb    <= {1'b0, sb[WIDTH-1:1]};
            psum  <= psum_nxt;
            carry <= slot_c;
            // Counter saturates on the last slot so it never wraps past WIDTH-1.
            cnt   <= last_slot ? cnt : cnt + CW'(1);
            if (last_slot) begin
                sum  <= psum_nxt;
                cout <= slot_c;
            end
        end
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2: directed vectors feed a scoreboard,
// a negedge monitor checks results, done latency and one-hot status on both instances.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    logic       s8, c8;
    logic [7:0] a8, b8;
    logic       rdy8, bsy8, dn8, cout8;
    logic [7:0] sum8;

    logic       s2, c2;
    logic [1:0] a2, b2;
    logic       rdy2, bsy2, dn2, cout2;
    logic [1:0] sum2;

    logic [8:0] exp8[$];
    logic [2:0] exp2[$];
    int         acc8[$];
    int         acc2[$];

    int npass  = 0;
    int ntotal = 0;
    int ncyc   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
        .ready(rdy8), .busy(bsy8), .done(dn8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2), .cin(c2),
        .ready(rdy2), .busy(bsy2), .done(dn2), .sum(sum2), .cout(cout2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Monitor: samples mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            acc8.delete();
            acc2.delete();
        end else begin
            check("onehot8", 32'($countones({rdy8, bsy8, dn8})), 32'd1);
            check("onehot2", 32'($countones({rdy2, bsy2, dn2})), 32'd1);
            if (rdy8 && s8) acc8.push_back(ncyc);
            if (rdy2 && s2) acc2.push_back(ncyc);
            if (dn8) begin
                if (exp8.size() == 0) check("done8_expected", 32'(exp8.size()), 32'd1);
                else check("result8", 32'({cout8, sum8}), 32'(exp8.pop_front()));
                if (acc8.size() == 0) check("accept8_seen", 32'(acc8.size()), 32'd1);
                else check("latency8", 32'(ncyc - acc8.pop_front()), 32'd9);
            end
            if (dn2) begin
                if (exp2.size() == 0) check("done2_expected", 32'(exp2.size()), 32'd1);
                else check("result2", 32'({cout2, sum2}), 32'(exp2.pop_front()));
                if (acc2.size() == 0) check("accept2_seen", 32'(acc2.size()), 32'd1);
                else check("latency2", 32'(ncyc - acc2.pop_front()), 32'd3);
            end
        end
    end

    task automatic wait_rdy8();
        int n = 0;
        while (!rdy8 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("ready8_reached", 32'(rdy8), 32'd1);
    endtask

    task automatic wait_rdy2();
        int n = 0;
        while (!rdy2 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("ready2_reached", 32'(rdy2), 32'd1);
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [8:0] exp);
        wait_rdy8();
        s8 = 1'b1; a8 = a; b8 = b; c8 = cin;
        exp8.push_back(exp);
        @(posedge clk); #2;
        // Scramble operands right after acceptance; the result must not notice.
        s8 = 1'b0; a8 = ~a; b8 = a ^ b; c8 = ~cin;
    endtask

    task automatic add2(input logic [1:0] a, input logic [1:0] b, input logic cin, input logic [2:0] exp);
        wait_rdy2();
        s2 = 1'b1; a2 = a; b2 = b; c2 = cin;
        exp2.push_back(exp);
        @(posedge clk); #2;
        s2 = 1'b0; a2 = ~a; b2 = ~b; c2 = ~cin;
    endtask

    initial begin
        rst_n = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        s2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0;
        #1;
        check("rst_ready8", 32'(rdy8), 32'd1);
        check("rst_busy8",  32'(bsy8), 32'd0);
        check("rst_done8",  32'(dn8),  32'd0);
        check("rst_sum8",   32'({cout8, sum8}), 32'd0);
        check("rst_ready2", 32'(rdy2), 32'd1);
        check("rst_sum2",   32'({cout2, sum2}), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        add8(8'h3C, 8'h0F, 1'b0, 9'h04B);
        add8(8'hFF, 8'h01, 1'b0, 9'h100);
        add8(8'hA5, 8'h5A, 1'b1, 9'h100);
        wait_rdy8();
        for (int i = 0; i < 4; i++) begin
            check("sum8_hold", 32'({cout8, sum8}), 32'h100);
            @(posedge clk); #2;
        end

        // Start held high for 30 cycles with operands changing every cycle.
        wait_rdy8();
        for (int i = 0; i < 30; i++) begin
            s8 = 1'b1;
            a8 = 8'(i * 29 + 200);
            b8 = 8'(i * 13 + 100);
            c8 = (i % 4 == 0);
            if (i == 0)  exp8.push_back(9'h12D);
            if (i == 10) exp8.push_back(9'h1D0);
            if (i == 20) exp8.push_back(9'h075);
            @(posedge clk); #2;
        end
        s8 = 1'b0;

        // Reset pulsed mid-RUN at cnt=4 aborts without a done pulse.
        wait_rdy8();
        s8 = 1'b1; a8 = 8'h11; b8 = 8'h22; c8 = 1'b0;
        @(posedge clk); #2;
        s8 = 1'b0;
        repeat (4) begin
            @(posedge clk); #2;
        end
        check("busy8_before_abort", 32'(bsy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ready8", 32'(rdy8), 32'd1);
        check("abort_busy8",  32'(bsy8), 32'd0);
        check("abort_sum8",   32'({cout8, sum8}), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        add8(8'h80, 8'h80, 1'b0, 9'h100);

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    add2(2'(a), 2'(b), 1'(c), 3'(a + b + c));

        begin
            int n = 0;
            while ((exp8.size() != 0 || exp2.size() != 0) && n < 200) begin
                @(posedge clk); #2;
                n++;
            end
        end
        repeat (4) @(posedge clk);
        #2;
        check("exp8_drained", 32'(exp8.size()), 32'd0);
        check("exp2_drained", 32'(exp2.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder cell over a WIDTH-bit operand pair, LSB first. The carry is held in a flip-flop between bit slots. The block sits between a requester (start/ready/done handshake) and the shared full-adder datapath. It replaces a WIDTH-bit ripple adder where area matters more than latency.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request. Sampled only while ready=1.
- a  in  WIDTH  operand A. Sampled on the accepting edge only.
- b  in  WIDTH  operand B. Sampled on the accepting edge only.
- cin  in  1  carry-in. Sampled on the accepting edge only.
- ready  out  1  high in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- sum  out  WIDTH  registered result. Holds until the next DONE.
- cout  out  1  registered carry-out. Holds until the next DONE.

## Operation
- The controller has three states: IDLE, RUN and DONE. Reset enters IDLE.
- IDLE:
  - ready=1.
  - On an edge with start=1: load shift registers sa<=a, sb<=b and carry<=cin, clear bit counter cnt<=0, clear the partial-sum shift register, then go to RUN.
  - start=0 stays in IDLE.
- RUN: each edge processes one bit slot.
  - s = sa[0]^sb[0]^carry.
  - carry <= majority(sa[0], sb[0], carry).
  - sa and sb shift right by one.
  - The partial-sum register shifts right with s entering at the MSB.
  - cnt increments.
  - On the edge where cnt==WIDTH-1 (the last slot): write sum <= the final partial sum (including this slot's s), write cout <= the carry produced in this slot, then go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge returns unconditionally to IDLE.
- The start input is ignored in RUN and DONE. There is no queuing.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
- Counter width is clog2(WIDTH). The counter never wraps past WIDTH-1.
- Operand inputs may change freely after the accepting edge without affecting the result.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - state=IDLE, ready=1, busy=0, done=0.
  - sum=0, cout=0.
  - carry, cnt, sa, sb and the partial-sum register = 0.
- Latency:
  - Start accepted at edge E0.
  - busy=1 during the cycles after E0 through E(WIDTH).
  - sum and cout update at edge E(WIDTH).
  - done=1 in the cycle between E(WIDTH) and E(WIDTH+1).
  - ready=1 again after E(WIDTH+1).
- Throughput: one addition per WIDTH+2 cycles. With start held high continuously, the next request is accepted at E(WIDTH+2).
- ready, busy and done are decoded from the state register only. They are mutually exclusive, and exactly one is high at any time.
- Reset asserted mid-RUN or mid-DONE:
  - Aborts the operation. No done pulse.
  - sum and cout clear to 0.
  - After rst_n deasserts, the first edge may accept a new start.

## Test plan
- WIDTH=8, a=0x3C, b=0x0F, cin=0, one-cycle start → done exactly 8 cycles after the accepting edge; sum=0x4B, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. sum holds 0x00 until the next done.
- WIDTH=8, start held high for 30 cycles, with a and b changed every cycle during RUN → accepts at E0, E10, E20 only. Each result matches the operands sampled at its accepting edge. Exactly one done per request.
- WIDTH=8, reset pulsed during RUN at cnt=4 → ready=1, sum=0 and cout=0 immediately; no done pulse. A following request with 0x80+0x80 gives sum=0x00, cout=1.
- WIDTH=2, exhaustive sweep of all 32 (a,b,cin) combinations → {cout,sum}==a+b+cin for every case. ready, busy and done are one-hot on every cycle.
